// File: rtl/riscv_fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package riscv_fetch_pkg;

    localparam int unsigned PC_INCR      = 4;
    localparam int unsigned ENTRY_PC_W   = 8;
    localparam int unsigned ENTRY_CODE_W = 32;

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } fetch_state_t;

    typedef struct packed {
        logic [ENTRY_CODE_W-1:0] code;
        logic [ENTRY_PC_W-1:0]   pc;
    } instr_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Prefetch FIFO with synchronous flush and a registered head entry.
module fetch_fifo
    import riscv_fetch_pkg::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   flush,
    input  logic                   push,
    input  instr_entry_t           push_data,
    input  logic                   pop,
    output logic [$clog2(DEPTH):0] count,
    output instr_entry_t           head
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

    instr_entry_t     mem_q [DEPTH];
    instr_entry_t     head_q, head_d;
    logic [PTR_W-1:0] wr_q, rd_q, rd_next;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_pop, do_push;

    always_comb begin
        rd_next = rd_q + PTR_W'(1);
        do_pop  = pop && (count_q != '0);
        do_push = push && ((count_q != CNT_W'(DEPTH)) || do_pop);
        count_d = count_q;
        head_d  = head_q;
        if (flush) begin
            count_d = '0;
        end else begin
            count_d = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
            // The head register mirrors mem_q[rd_q]; refresh it whenever the read side moves.
            if (do_pop) begin
                if (count_q == CNT_W'(1)) begin
                    if (do_push) head_d = push_data;
                end else begin
                    head_d = mem_q[rd_next];
                end
            end else if (do_push && (count_q == '0)) begin
                head_d = push_data;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
            wr_q    <= '0;
            rd_q    <= '0;
            count_q <= '0;
            head_q  <= '0;
        end else begin
            count_q <= count_d;
            head_q  <= head_d;
            if (flush) begin
                wr_q <= '0;
                rd_q <= '0;
            end else begin
                if (do_push) begin
                    mem_q[wr_q] <= push_data;
                    wr_q        <= wr_q + PTR_W'(1);
                end
                if (do_pop) rd_q <= rd_next;
            end
        end
    end

    assign count = count_q;
    assign head  = head_q;

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch stage: PC generation, credit-limited memory requests, prefetch buffering
// and redirect handling with stale-response discard.
module instr_fetch
    import riscv_fetch_pkg::*;
#(
    parameter int unsigned PC_W       = ENTRY_PC_W,
    parameter int unsigned IMS_W      = ENTRY_CODE_W,
    parameter int unsigned FIFO_DEPTH = 2,
    parameter int unsigned RESET_PC   = 0
) (
    input  logic             clk,
    input  logic             reset,
    output logic             imem_req_valid,
    input  logic             imem_req_ready,
    output logic [PC_W-1:0]  imem_req_addr,
    input  logic             imem_rsp_valid,
    input  logic [IMS_W-1:0] imem_rsp_data,
    input  logic             redirect_valid,
    input  logic [PC_W-1:0]  redirect_pc,
    output logic             instr_valid,
    input  logic             instr_ready,
    output logic [IMS_W-1:0] instr_code,
    output logic [PC_W-1:0]  instr_pc
);

    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;
    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);

    fetch_state_t     state_q, state_d;
    logic [PC_W-1:0]  fetch_pc_q, fetch_pc_d;
    logic [CNT_W-1:0] outstanding_q, outstanding_d;
    logic [CNT_W-1:0] discard_q, discard_d;
    logic [PC_W-1:0]  pcq_q [FIFO_DEPTH];
    logic [PTR_W-1:0] pcq_wr_q, pcq_rd_q;
    logic [CNT_W-1:0] fifo_count;
    logic [CNT_W:0]   used;
    logic             req_fire, pop, push, credit_free;
    instr_entry_t     push_entry, head;

    always_comb begin
        pop         = instr_valid && instr_ready;
        // A pop out of a full FIFO only returns its credit on the next cycle.
        credit_free = pop && (fifo_count != CNT_W'(FIFO_DEPTH));
        used        = {1'b0, fifo_count} + {1'b0, outstanding_q} - (CNT_W + 1)'(credit_free);
        imem_req_valid = (state_q == RUN) && (used < (CNT_W + 1)'(FIFO_DEPTH));
        req_fire       = imem_req_valid && imem_req_ready;
        push           = imem_rsp_valid && !redirect_valid && (discard_q == '0);
        outstanding_d  = outstanding_q + CNT_W'(req_fire) - CNT_W'(imem_rsp_valid);

        push_entry.code = imem_rsp_data;
        push_entry.pc   = pcq_q[pcq_rd_q];

        discard_d = discard_q;
        if (redirect_valid) begin
            discard_d = outstanding_d;
        end else if (imem_rsp_valid && (discard_q != '0)) begin
            discard_d = discard_q - CNT_W'(1);
        end

        fetch_pc_d = fetch_pc_q;
        if (redirect_valid) begin
            fetch_pc_d = redirect_pc & ~PC_W'(3);
        end else if (req_fire) begin
            fetch_pc_d = fetch_pc_q + PC_W'(PC_INCR);
        end

        state_d = state_q;
        if (redirect_valid) begin
            state_d = (outstanding_d != '0) ? DRAIN : RUN;
        end else begin
            case (state_q)
                BOOT:    state_d = RUN;
                RUN:     state_d = RUN;
                DRAIN:   if (discard_d == '0) state_d = RUN;
                default: state_d = BOOT;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= BOOT;
            fetch_pc_q    <= PC_W'(RESET_PC);
            outstanding_q <= '0;
            discard_q     <= '0;
        end else begin
            state_q       <= state_d;
            fetch_pc_q    <= fetch_pc_d;
            outstanding_q <= outstanding_d;
            discard_q     <= discard_d;
        end
    end

    // In-flight PC queue: stale entries are retired by their (discarded) responses.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int unsigned i = 0; i < FIFO_DEPTH; i++) pcq_q[i] <= '0;
            pcq_wr_q <= '0;
            pcq_rd_q <= '0;
        end else begin
            if (req_fire) begin
                pcq_q[pcq_wr_q] <= fetch_pc_q;
                pcq_wr_q        <= pcq_wr_q + PTR_W'(1);
            end
            if (imem_rsp_valid) pcq_rd_q <= pcq_rd_q + PTR_W'(1);
        end
    end

    fetch_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .flush     (redirect_valid),
        .push      (push),
        .push_data (push_entry),
        .pop       (pop),
        .count     (fifo_count),
        .head      (head)
    );

    assign imem_req_addr = fetch_pc_q;
    assign instr_valid   = (fifo_count != '0);
    assign instr_code    = head.code;
    assign instr_pc      = head.pc;

endmodule

// File: tb/tb_instr_fetch.sv
// Directed + randomized bench for instr_fetch with a latency-configurable ROM and a
// stream-level model of the expected fetch and delivery order.
module tb_instr_fetch;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        imem_req_valid;
    logic        imem_req_ready = 1'b0;
    logic [7:0]  imem_req_addr;
    logic        imem_rsp_valid = 1'b0;
    logic [31:0] imem_rsp_data = '0;
    logic        redirect_valid = 1'b0;
    logic [7:0]  redirect_pc = '0;
    logic        instr_valid;
    logic        instr_ready = 1'b0;
    logic [31:0] instr_code;
    logic [7:0]  instr_pc;

    instr_fetch #(
        .PC_W       (8),
        .IMS_W      (32),
        .FIFO_DEPTH (2),
        .RESET_PC   (0)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .instr_valid    (instr_valid),
        .instr_ready    (instr_ready),
        .instr_code     (instr_code),
        .instr_pc       (instr_pc)
    );

    always #5 clk = ~clk;

    int          n_tests = 0;
    int          n_fail = 0;
    int          cyc = 0;
    int          lat = 1;
    int          mem_mode = 1;  // 0 never ready, 1 always ready, 2 random
    int          ir_mode = 1;
    int unsigned due_q[$];
    logic [7:0]  addr_q[$];
    logic [7:0]  exp_fetch = '0;
    logic [7:0]  exp_pc = '0;
    int          n_req = 0;
    int          n_pop = 0;
    int          n0;
    bit          s_req_valid, redir_hit;

    function automatic logic [31:0] rom(input logic [7:0] a);
        return {8'hC3, a, ~a, a ^ 8'h5A};
    endfunction

    function automatic logic pick(input int mode);
        if (mode == 0) return 1'b0;
        if (mode == 1) return 1'b1;
        return ($urandom_range(0, 3) != 0);
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // One clock cycle: drive at negedge, sample #1 later, update memory and stream model.
    // mode 0: no redirect, 1: redirect, 2: redirect only alongside a response and a pop.
    task automatic step(input int mode, input logic [7:0] rpc);
        bit rsp_now, rd;
        @(negedge clk);
        imem_req_ready = pick(mem_mode);
        instr_ready    = pick(ir_mode);
        rsp_now        = (due_q.size() > 0) && (due_q[0] == cyc);
        imem_rsp_valid = rsp_now;
        imem_rsp_data  = rsp_now ? rom(addr_q[0]) : $urandom();
        if (rsp_now) begin
            void'(due_q.pop_front());
            void'(addr_q.pop_front());
        end
        rd = (mode == 1) || (mode == 2 && rsp_now && instr_valid && instr_ready);
        redirect_valid = rd;
        redirect_pc    = rd ? rpc : 8'($urandom());
        #1;
        s_req_valid = imem_req_valid;
        redir_hit   = rd;
        if (imem_req_valid) check("req_addr", 32'(imem_req_addr), 32'(exp_fetch));
        if (instr_valid) check("instr_code", instr_code, rom(instr_pc));
        if (instr_valid && instr_ready) begin
            check("instr_pc", 32'(instr_pc), 32'(exp_pc));
            exp_pc += 8'd4;
            n_pop++;
        end
        if (imem_req_valid && imem_req_ready) begin
            due_q.push_back(cyc + lat);
            addr_q.push_back(imem_req_addr);
            exp_fetch += 8'd4;
            n_req++;
        end
        if (rd) begin
            exp_fetch = rpc & 8'hFC;
            exp_pc    = rpc & 8'hFC;
        end
        check("outstanding_bound", (due_q.size() <= 2) ? 32'd1 : 32'd0, 32'd1);
        cyc++;
    endtask

    task automatic apply_reset();
        reset = 1'b0;
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b0;
        redirect_valid = 1'b0;
        instr_ready    = 1'b0;
        due_q.delete();
        addr_q.delete();
        exp_fetch = '0;
        exp_pc    = '0;
        repeat (2) @(negedge clk);
        #1;
        check("rst_req_valid", 32'(imem_req_valid), 0);
        check("rst_req_addr", 32'(imem_req_addr), 0);
        check("rst_instr_valid", 32'(instr_valid), 0);
        check("rst_instr_code", instr_code, 0);
        check("rst_instr_pc", 32'(instr_pc), 0);
        @(negedge clk);
        reset = 1'b1;
        #1;
        check("boot_no_req", 32'(imem_req_valid), 0);
    endtask

    task automatic set_lat(input int l);
        mem_mode = 0;
        for (int i = 0; i < 20 && due_q.size() != 0; i++) step(0, 8'h00);
        check("drain_for_lat", due_q.size(), 0);
        lat = l;
        mem_mode = 1;
    endtask

    // Redirect, then require the first new request right after the last stale response.
    task automatic redirect_check(input int mode, input logic [7:0] rpc, input string tag);
        int expect_cyc;
        redir_hit = 1'b0;
        for (int i = 0; i < 40; i++) begin
            step(mode, rpc);
            if (redir_hit) break;
        end
        check({tag, "_hit"}, 32'(redir_hit), 1);
        expect_cyc = (due_q.size() > 0) ? int'(due_q[$]) + 1 : cyc;
        for (int i = 0; i < 40; i++) begin
            step(0, 8'h00);
            if (s_req_valid) break;
        end
        check({tag, "_gap"}, 32'(cyc - 1), 32'(expect_cyc));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        apply_reset();
        lat = 1;
        mem_mode = 1;
        ir_mode = 0;
        step(0, 8'h00);
        check("first_req", 32'(s_req_valid), 1);
        repeat (11) step(0, 8'h00);
        check("bp_req_count", n_req, 2);
        check("bp_valid", 32'(instr_valid), 1);
        check("bp_head_pc", 32'(instr_pc), 0);
        check("bp_head_code", instr_code, rom(8'h00));

        ir_mode = 1;
        repeat (5) step(0, 8'h00);
        n0 = n_pop;
        repeat (10) step(0, 8'h00);
        check("throughput", n_pop - n0, 10);

        set_lat(3);
        for (int i = 0; i < 20 && due_q.size() != 2; i++) step(0, 8'h00);
        check("two_outstanding", due_q.size(), 2);
        redirect_check(1, 8'h40, "stale_drop");
        n0 = n_pop;
        repeat (12) step(0, 8'h00);
        check("post_redirect_progress", (n_pop > n0) ? 32'd1 : 32'd0, 32'd1);

        set_lat(1);
        repeat (6) step(0, 8'h00);
        redirect_check(2, 8'h80, "same_cycle");
        repeat (8) step(0, 8'h00);

        redirect_check(1, 8'hFE, "wrap");
        repeat (10) step(0, 8'h00);

        for (int l = 1; l <= 3; l++) begin
            set_lat(l);
            mem_mode = 2;
            ir_mode = 2;
            repeat (150) step(($urandom_range(0, 19) == 0) ? 1 : 0, 8'($urandom()));
        end

        ir_mode = 1;
        set_lat(1);
        ir_mode = 0;
        repeat (6) step(0, 8'h00);
        check("full_before_reset", 32'(instr_valid), 1);
        @(negedge clk);
        imem_rsp_valid = 1'b0;
        redirect_valid = 1'b0;
        #2;
        reset = 1'b0;
        #1;
        check("midrst_instr_valid", 32'(instr_valid), 0);
        check("midrst_req_valid", 32'(imem_req_valid), 0);
        check("midrst_req_addr", 32'(imem_req_addr), 0);
        due_q.delete();
        addr_q.delete();
        exp_fetch = '0;
        exp_pc    = '0;
        @(negedge clk);
        reset = 1'b1;
        ir_mode = 1;
        step(0, 8'h00);
        check("restart_req", 32'(s_req_valid), 1);
        n0 = n_pop;
        repeat (10) step(0, 8'h00);
        check("restart_progress", (n_pop > n0) ? 32'd1 : 32'd0, 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
